// File: rtl/arith_seq_pkg.sv
// rtl/arith_seq_pkg.sv - shared types and helpers for the arithmetic sequencer
// Purpose: operation and FSM state encodings, plus the slot-to-operation mapping.
// Ports: none (package).
package arith_seq_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef enum logic [2:0] {IDLE, ADDR_A, ADDR_B, LOAD, EXEC, OUT, DONE} state_t;

  // Operations rotate through ADD, SUB, MUL, DIV as the slot index advances.
  function automatic op_t op_of_slot(input int unsigned k);
    logic [1:0] low;
    low = k[1:0];
    return op_t'(low);
  endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// rtl/iter_muldiv_core.sv - iterative shift-add multiplier and restoring divider
// Purpose: one multiplier bit (LSB first) or one quotient bit (MSB first) per cycle.
// Ports: clk, rst_n; load/op/a/b start an operation; busy while iterating;
//        fin marks the final iteration cycle, during which result/rem already
//        show the finished values (so the caller can register them that edge).
module iter_muldiv_core
  import arith_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  op_t                op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               run_q, run_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // Holds the multiplier for MUL, and the dividend shifting into the quotient for DIV.
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;

  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     trial, trial_sub;
  logic               ge;
  logic [WIDTH-1:0]   rem_step, quo_step;

  always_comb begin
    prod_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    trial     = {rem_q, mplier_q[WIDTH-1]};
    trial_sub = trial - {1'b0, dvsr_q};
    ge        = (trial >= {1'b0, dvsr_q});
    rem_step  = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step  = (mplier_q << 1) | WIDTH'(ge);

    fin    = (cnt_q == CW'(WIDTH - 1));
    busy   = run_q;
    result = div_q ? {{WIDTH{1'b0}}, quo_step} : prod_step;
    rem    = div_q ? rem_step : '0;

    run_d    = run_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;

    if (load) begin
      run_d    = 1'b1;
      div_d    = (op == OP_DIV);
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = (op == OP_DIV) ? a : b;
      rem_d    = '0;
      dvsr_d   = b;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        rem_d    = rem_step;
        mplier_d = quo_step;
      end else begin
        acc_d    = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      if (fin) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      run_q    <= run_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
    end
  end

endmodule

// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - ROM-driven four-operation calculator sequencer
// Purpose: fetches NUM_OPS operand pairs from a synchronous ROM, runs
//          ADD/SUB/MUL/DIV in slot order and presents each result on a
//          valid/ready port.
// Ports: clk, rst_n (sync active-low); start; rom_addr/rom_data (1-cycle ROM);
//        res_valid/res_ready handshake with res_op, res_value, res_rem,
//        res_neg, res_div0; busy (not IDLE); done (one-cycle end-of-run pulse).
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_OPS   = 4,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [1:0]         res_op,
  output logic [2*WIDTH-1:0] res_value,
  output logic [WIDTH-1:0]   res_rem,
  output logic               res_neg,
  output logic               res_div0,
  output logic               busy,
  output logic               done
);

  localparam int KW = $clog2(NUM_OPS + 1);
  localparam int RW = 2 * WIDTH;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  op_t                op_q, op_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               res_valid_q, res_valid_d;
  op_t                res_op_q, res_op_d;
  logic [RW-1:0]      res_value_q, res_value_d;
  logic [WIDTH-1:0]   res_rem_q, res_rem_d;
  logic               res_neg_q, res_neg_d;
  logic               res_div0_q, res_div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               core_load, core_busy, core_fin;
  logic [RW-1:0]      core_result;
  logic [WIDTH-1:0]   core_rem;

  op_t                op_k;
  logic [KW-1:0]      k_inc;
  logic [ADDR_W-1:0]  addr_a, addr_next;

  logic               ex_fin, ex_neg, ex_div0;
  logic [RW-1:0]      ex_val;
  logic [WIDTH-1:0]   ex_rem;

  iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .op     (op_k),
    .a      (a_q),
    .b      (rom_data),
    .busy   (core_busy),
    .fin    (core_fin),
    .result (core_result),
    .rem    (core_rem)
  );

  always_comb begin
    op_k      = op_of_slot(32'(k_q));
    k_inc     = k_q + KW'(1);
    addr_a    = ADDR_W'(BASE_ADDR) + ADDR_W'({k_q, 1'b0});
    addr_next = ADDR_W'(BASE_ADDR) + ADDR_W'({k_inc, 1'b0});
  end

  // Result of the EXEC state; ADD, SUB and divide-by-zero finish in one cycle.
  always_comb begin
    ex_fin  = 1'b0;
    ex_val  = '0;
    ex_rem  = '0;
    ex_neg  = 1'b0;
    ex_div0 = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_fin = 1'b1;
        ex_val = RW'(a_q) + RW'(b_q);
      end
      OP_SUB: begin
        // Wrapping at 2*WIDTH equals the sign-extended WIDTH+1 bit difference.
        ex_fin = 1'b1;
        ex_val = RW'(a_q) - RW'(b_q);
        ex_neg = (a_q < b_q);
      end
      OP_MUL: begin
        ex_fin = core_busy && core_fin;
        ex_val = core_result;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          ex_fin  = 1'b1;
          ex_rem  = a_q;
          ex_div0 = 1'b1;
        end else begin
          ex_fin = core_busy && core_fin;
          ex_val = core_result;
          ex_rem = core_rem;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rom_addr_d  = rom_addr_q;
    res_valid_d = res_valid_q;
    res_op_d    = res_op_q;
    res_value_d = res_value_q;
    res_rem_d   = res_rem_q;
    res_neg_d   = res_neg_q;
    res_div0_d  = res_div0_q;
    done_d      = 1'b0;
    core_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ADDR_A;
          rom_addr_d = addr_a;
        end
      end
      ADDR_A: begin
        rom_addr_d = addr_a + ADDR_W'(1);
        state_d    = ADDR_B;
      end
      ADDR_B: begin
        a_d     = rom_data;
        state_d = LOAD;
      end
      LOAD: begin
        b_d       = rom_data;
        op_d      = op_k;
        core_load = (op_k == OP_MUL) || ((op_k == OP_DIV) && (rom_data != '0));
        state_d   = EXEC;
      end
      EXEC: begin
        if (ex_fin) begin
          res_valid_d = 1'b1;
          res_op_d    = op_q;
          res_value_d = ex_val;
          res_rem_d   = ex_rem;
          res_neg_d   = ex_neg;
          res_div0_d  = ex_div0;
          state_d     = OUT;
        end
      end
      OUT: begin
        // res_valid is always high here, so res_ready alone completes the handshake.
        if (res_ready) begin
          res_valid_d = 1'b0;
          k_d         = k_inc;
          if (k_inc == KW'(NUM_OPS)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ADDR_A;
            rom_addr_d = addr_next;
          end
        end
      end
      DONE: begin
        k_d        = '0;
        rom_addr_d = ADDR_W'(BASE_ADDR);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      rom_addr_q  <= ADDR_W'(BASE_ADDR);
      res_valid_q <= 1'b0;
      res_op_q    <= OP_ADD;
      res_value_q <= '0;
      res_rem_q   <= '0;
      res_neg_q   <= 1'b0;
      res_div0_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rom_addr_q  <= rom_addr_d;
      res_valid_q <= res_valid_d;
      res_op_q    <= res_op_d;
      res_value_q <= res_value_d;
      res_rem_q   <= res_rem_d;
      res_neg_q   <= res_neg_d;
      res_div0_q  <= res_div0_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_value = res_value_q;
  assign res_rem   = res_rem_q;
  assign res_neg   = res_neg_q;
  assign res_div0  = res_div0_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// tb/tb_arith_sequencer.sv - self-checking bench for arith_sequencer
module tb_arith_sequencer;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int AW   = 9;
  localparam int BASE = 6;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] val;
    logic [7:0]  rem;
    logic        neg;
    logic        div0;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          res_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;
  logic          res_valid;
  logic [1:0]    res_op;
  logic [15:0]   res_value;
  logic [7:0]    res_rem;
  logic          res_neg, res_div0, busy, done;

  logic [7:0]    rom_mem [512];
  vec_t          tbl [12];
  vec_t          cur [N];

  int cyc = 0;
  int t_ref = 0;
  int n_vec = 0;
  int n_err = 0;

  arith_sequencer #(.WIDTH(W), .NUM_OPS(N), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_value (res_value),
    .res_rem   (res_rem),
    .res_neg   (res_neg),
    .res_div0  (res_div0),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // Reference: results derived directly from the arithmetic definition of each slot.
  function automatic vec_t model(input int slot, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a = a; v.b = b; v.val = '0; v.rem = '0; v.neg = 1'b0; v.div0 = 1'b0;
    case (slot % 4)
      0: v.val = 16'(a) + 16'(b);
      1: begin v.val = 16'(a) - 16'(b); v.neg = (a < b); end
      2: v.val = 16'(a) * 16'(b);
      default: begin
        if (b == 8'd0) begin
          v.rem = a; v.div0 = 1'b1;
        end else begin
          v.val = 16'(a / b); v.rem = a % b;
        end
      end
    endcase
    return v;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [15:0] val,
                              input logic [7:0] rem, input logic neg, input logic div0);
    vec_t v;
    v.a = a; v.b = b; v.val = val; v.rem = rem; v.neg = neg; v.div0 = div0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_cur();
    for (int s = 0; s < N; s++) begin
      rom_mem[BASE + 2*s]     = cur[s].a;
      rom_mem[BASE + 2*s + 1] = cur[s].b;
    end
  endtask

  task automatic serve_slot(input int slot, input vec_t v, input int stall);
    int waited;
    int exp_e;
    exp_e = ((slot % 4 == 2) || ((slot % 4 == 3) && (v.b != 8'd0))) ? W : 1;
    if (stall > 0) res_ready = 1'b0;
    waited = 0;
    while (res_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("slot%0d valid_seen", slot), 32'(res_valid), 32'd1);
    if (res_valid !== 1'b1) begin
      res_ready = 1'b1;
      return;
    end
    check($sformatf("slot%0d latency", slot), cyc - t_ref, 3 + exp_e);
    check($sformatf("slot%0d op", slot), 32'(res_op), slot % 4);
    check($sformatf("slot%0d value", slot), 32'(res_value), 32'(v.val));
    check($sformatf("slot%0d rem", slot), 32'(res_rem), 32'(v.rem));
    check($sformatf("slot%0d neg", slot), 32'(res_neg), 32'(v.neg));
    check($sformatf("slot%0d div0", slot), 32'(res_div0), 32'(v.div0));
    check($sformatf("slot%0d busy", slot), 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check($sformatf("slot%0d stall valid", slot), 32'(res_valid), 32'd1);
      check($sformatf("slot%0d stall value", slot), 32'(res_value), 32'(v.val));
      check($sformatf("slot%0d stall addr", slot), 32'(rom_addr), BASE + 2*slot + 1);
    end
    res_ready = 1'b1;
    t_ref = cyc + 1;
    @(negedge clk);
    check($sformatf("slot%0d valid_fall", slot), 32'(res_valid), 32'd0);
  endtask

  task automatic run_cur(input bit do_start, input int stall_slot, input int stall_len,
                         input bit chain, input bit pulse_busy);
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      t_ref = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      if (pulse_busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int s = 0; s < N; s++) begin
      if (chain && s == N - 1) start = 1'b1;
      serve_slot(s, cur[s], (s == stall_slot) ? stall_len : 0);
    end
    check("done pulse", 32'(done), 32'd1);
    @(negedge clk);
    check("done fall", 32'(done), 32'd0);
    check("idle after done", 32'(busy), 32'd0);
    if (chain) begin
      t_ref = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      check("held start relaunch busy", 32'(busy), 32'd1);
      check("held start relaunch addr", 32'(rom_addr), BASE);
    end else begin
      repeat (3) @(negedge clk);
      check("stays idle busy", 32'(busy), 32'd0);
      check("stays idle valid", 32'(res_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = 8'($urandom);

    tbl[0]  = mk(8'd200, 8'd100, 16'h012C, 8'd0, 1'b0, 1'b0);
    tbl[1]  = mk(8'd5,   8'd9,   16'hFFFC, 8'd0, 1'b1, 1'b0);
    tbl[2]  = mk(8'd255, 8'd255, 16'hFE01, 8'd0, 1'b0, 1'b0);
    tbl[3]  = mk(8'd100, 8'd7,   16'd14,   8'd2, 1'b0, 1'b0);
    tbl[4]  = mk(8'd1,   8'd2,   16'd3,    8'd0, 1'b0, 1'b0);
    tbl[5]  = mk(8'd9,   8'd5,   16'd4,    8'd0, 1'b0, 1'b0);
    tbl[6]  = mk(8'd0,   8'd7,   16'd0,    8'd0, 1'b0, 1'b0);
    tbl[7]  = mk(8'd5,   8'd0,   16'd0,    8'd5, 1'b0, 1'b1);
    tbl[8]  = mk(8'd255, 8'd255, 16'h01FE, 8'd0, 1'b0, 1'b0);
    tbl[9]  = mk(8'd0,   8'd255, 16'hFF01, 8'd0, 1'b1, 1'b0);
    tbl[10] = mk(8'd13,  8'd0,   16'd0,    8'd0, 1'b0, 1'b0);
    tbl[11] = mk(8'd3,   8'd200, 16'd0,    8'd3, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset valid", 32'(res_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset value", 32'(res_value), 32'd0);
    check("reset rem", 32'(res_rem), 32'd0);
    check("reset op", 32'(res_op), 32'd0);
    check("reset neg_div0", 32'({res_neg, res_div0}), 32'd0);
    check("reset addr", 32'(rom_addr), BASE);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven runs; the first one also backpressures slot 1 for 6 cycles
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < N; s++) cur[s] = tbl[4*r + s];
      load_cur();
      run_cur(1'b1, (r == 0) ? 1 : -1, 6, 1'b0, 1'b0);
    end

    // Reset in the middle of the slot-2 multiply, then a fresh run
    for (int s = 0; s < N; s++) cur[s] = tbl[s];
    load_cur();
    @(negedge clk);
    start = 1'b1;
    t_ref = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    serve_slot(0, cur[0], 0);
    serve_slot(1, cur[1], 0);
    repeat (4) @(negedge clk);
    check("mid-exec busy", 32'(busy), 32'd1);
    check("mid-exec valid", 32'(res_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset valid", 32'(res_valid), 32'd0);
    check("post-reset addr", 32'(rom_addr), BASE);
    check("post-reset value", 32'(res_value), 32'd0);
    repeat (2) @(negedge clk);
    check("post-reset idle", 32'(busy), 32'd0);
    run_cur(1'b1, -1, 0, 1'b0, 1'b0);

    // Randomized runs against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < N; s++) begin
        logic [7:0] ra, rb;
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (s == 3 && r % 3 == 0) rb = 8'd0;
        if (s == 2 && r == 4) rb = 8'd0;
        cur[s] = model(s, ra, rb);
      end
      load_cur();
      run_cur(1'b1, $urandom_range(0, N - 1), $urandom_range(0, 3), 1'b0, (r == 1));
    end

    // start held high across DONE launches a second run from slot 0
    for (int s = 0; s < N; s++) cur[s] = tbl[4 + s];
    load_cur();
    run_cur(1'b1, -1, 0, 1'b1, 1'b0);
    run_cur(1'b0, -1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
